// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor with start/busy/done handshake
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int B     = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    step;

  logic [B:0]       chunk;
  logic [WIDTH-1:0] chunk_ext;
  logic [WIDTH-1:0] acc_next;
  logic             msb_cin;
  logic             last;

  // One chunk of the ripple: low bits of both operands plus the carry flop,
  // with the result chunk entering the accumulator from the MSB end.
  always_comb begin
    chunk     = {1'b0, op_a[B-1:0]} + {1'b0, op_b[B-1:0]} + {{B{1'b0}}, carry};
    chunk_ext = WIDTH'(chunk[B-1:0]);
    acc_next  = (acc >> B) | (chunk_ext << (WIDTH - B));
    // Carry into the top bit of this chunk, recovered from its sum bit;
    // only meaningful on the last step where that bit is the operand MSB.
    msb_cin   = op_a[B-1] ^ op_b[B-1] ^ chunk[B-1];
    last      = (step == CW'(STEPS - 1));
  end

  // Control FSM and datapath registers; outputs are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      step     <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1, so invert B and force the carry.
            op_a  <= a;
            op_b  <= mode ? ~b : b;
            carry <= mode ? 1'b1 : cin;
            step  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          op_a  <= op_a >> B;
          op_b  <= op_b >> B;
          acc   <= acc_next;
          carry <= chunk[B];
          step  <= step + 1'b1;
          if (last) begin
            sum      <= acc_next;
            cout     <= chunk[B];
            overflow <= msb_cin ^ chunk[B];
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (8x1 and 16x4 configurations)
module tb_serial_adder;

  logic        clk;
  logic        rst8, start8, mode8, cin8;
  logic [7:0]  a8, b8, sum8;
  logic        cout8, ovf8, busy8, done8;
  logic        rst16, start16, mode16, cin16;
  logic [15:0] a16, b16, sum16;
  logic        cout16, ovf16, busy16, done16;

  int total = 0;
  int bad   = 0;

  logic [17:0] exp8[$];
  logic [17:0] exp16[$];

  logic [7:0]  prev_sum8;
  logic [15:0] prev_sum16;
  logic        rst_prev8  = 1'b1;
  logic        rst_prev16 = 1'b1;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .mode(mode8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .overflow(ovf8), .busy(busy8), .done(done8)
  );

  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u16 (
    .clk(clk), .rst(rst16), .start(start16), .mode(mode16), .a(a16), .b(b16), .cin(cin16),
    .sum(sum16), .cout(cout16), .overflow(ovf16), .busy(busy16), .done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values; returns {overflow, cout, sum}.
  function automatic logic [17:0] model(input int w, input logic m, input logic [15:0] x,
                                        input logic [15:0] y, input logic c);
    longint lim, ux, uy, sx, sy, full, sr;
    logic   co, v;
    lim = longint'(1) << w;
    ux  = longint'(x) & (lim - 1);
    uy  = longint'(y) & (lim - 1);
    sx  = (ux >= lim / 2) ? ux - lim : ux;
    sy  = (uy >= lim / 2) ? uy - lim : uy;
    if (!m) begin
      full = ux + uy + longint'(c);
      co   = (full >= lim);
      sr   = sx + sy + longint'(c);
    end else begin
      full = ux - uy + lim;
      co   = (ux >= uy);
      sr   = sx - sy;
    end
    v = (sr >= lim / 2) || (sr < -(lim / 2));
    return {v, co, 16'(full % lim)};
  endfunction

  // Monitor for the 8-bit unit: compare on done, otherwise the result must hold.
  always @(negedge clk) begin
    if (done8) begin
      if (exp8.size() == 0) begin
        total++; bad++;
        $display("FAIL d8_spurious_done: got done=1 expected no pending op");
      end else begin
        check("d8_result", {ovf8, cout8, 8'h00, sum8}, exp8.pop_front());
      end
    end else if (!rst_prev8) begin
      check("d8_sum_hold", sum8, prev_sum8);
    end
    prev_sum8 = sum8;
    rst_prev8 = rst8;
  end

  // Monitor for the 16-bit unit.
  always @(negedge clk) begin
    if (done16) begin
      if (exp16.size() == 0) begin
        total++; bad++;
        $display("FAIL d16_spurious_done: got done=1 expected no pending op");
      end else begin
        check("d16_result", {ovf16, cout16, sum16}, exp16.pop_front());
      end
    end else if (!rst_prev16) begin
      check("d16_sum_hold", sum16, prev_sum16);
    end
    prev_sum16 = sum16;
    rst_prev16 = rst16;
  end

  task automatic op8(input logic m, input logic [7:0] x, input logic [7:0] y, input logic c);
    int n, nb;
    @(posedge clk); #1;
    n = 0;
    while (busy8 && n < 100) begin @(posedge clk); #1; n++; end
    start8 = 1'b1; mode8 = m; a8 = x; b8 = y; cin8 = c;
    exp8.push_back(model(8, m, x, y, c));
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom); cin8 = 1'($urandom);
    n = 0; nb = 0;
    do begin
      @(negedge clk); n++;
      if (busy8) nb++;
    end while (!done8 && n < 50);
    check("d8_latency", n, 9);
    check("d8_busy_cycles", nb, 9);
    @(negedge clk);
    check("d8_idle_after_done", busy8, 0);
  endtask

  task automatic op16(input logic m, input logic [15:0] x, input logic [15:0] y, input logic c);
    int n, nb;
    @(posedge clk); #1;
    n = 0;
    while (busy16 && n < 100) begin @(posedge clk); #1; n++; end
    start16 = 1'b1; mode16 = m; a16 = x; b16 = y; cin16 = c;
    exp16.push_back(model(16, m, x, y, c));
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); mode16 = 1'($urandom); cin16 = 1'($urandom);
    n = 0; nb = 0;
    do begin
      @(negedge clk); n++;
      if (busy16) nb++;
    end while (!done16 && n < 50);
    check("d16_latency", n, 5);
    check("d16_busy_cycles", nb, 5);
    @(negedge clk);
    check("d16_idle_after_done", busy16, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst8 = 1'b1; start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst16 = 1'b1; start16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset8_outputs", {ovf8, cout8, busy8, done8, sum8}, 0);
    check("reset16_outputs", {ovf16, cout16, busy16, done16, sum16}, 0);
    @(posedge clk); #1;
    rst8 = 1'b0; rst16 = 1'b0;

    // Directed cases from the plan, each also held against fixed constants.
    op8(1'b0, 8'h3C, 8'h5A, 1'b0);
    check("k_3c_plus_5a", {ovf8, cout8, sum8}, {1'b1, 1'b0, 8'h96});
    op8(1'b0, 8'hFF, 8'h01, 1'b0);
    check("k_ff_plus_01", {ovf8, cout8, sum8}, {1'b0, 1'b1, 8'h00});
    op8(1'b0, 8'h7F, 8'h00, 1'b1);
    check("k_7f_plus_cin", {ovf8, sum8}, {1'b1, 8'h80});
    op8(1'b1, 8'h10, 8'h20, 1'b1);
    check("k_10_minus_20", {ovf8, cout8, sum8}, {1'b0, 1'b0, 8'hF0});
    op8(1'b1, 8'h80, 8'h01, 1'b0);
    check("k_80_minus_01", {ovf8, cout8, sum8}, {1'b1, 1'b1, 8'h7F});

    // Start pulsed again mid-RUN must be ignored.
    @(posedge clk); #1;
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h21; b8 = 8'h13; cin8 = 1'b0;
    exp8.push_back(model(8, 1'b0, 8'h21, 8'h13, 1'b0));
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk); #1;
    start8 = 1'b1; mode8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    check("ignore_done_seen", done8, 1);
    check("ignore_result", sum8, 8'h34);
    repeat (15) @(negedge clk);
    check("ignore_queue_empty", exp8.size(), 0);

    // Reset asserted while step 4 is being processed.
    @(posedge clk); #1;
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    @(negedge clk);
    check("abort_outputs", {ovf8, cout8, busy8, done8, sum8}, 0);
    repeat (12) @(negedge clk);
    op8(1'b0, 8'h01, 8'h01, 1'b0);
    check("after_abort_sum", sum8, 8'h02);

    // Reset and start at the same edge: reset wins.
    @(posedge clk); #1;
    rst8 = 1'b1; start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; mode8 = 1'b0;
    @(posedge clk); #1;
    rst8 = 1'b0; start8 = 1'b0;
    @(negedge clk);
    check("rst_start_busy", busy8, 0);
    repeat (12) @(negedge clk);

    // 16-bit, four bits per cycle.
    op16(1'b0, 16'h1234, 16'h0FFF, 1'b0);
    check("k16_1234_plus_0fff", {cout16, sum16}, {1'b0, 16'h2233});
    op16(1'b1, 16'h8000, 16'h0001, 1'b0);
    op16(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);

    // Random sweeps.
    repeat (25) op8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    repeat (25) op16(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));

    repeat (5) @(negedge clk);
    check("q8_drained", exp8.size(), 0);
    check("q16_drained", exp16.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
